fetch_block: RTL and testbench

Instruction-fetch stage of the pipelined Thumb CPU; the producer side of the fetch→decode interface that `decode_block` consumes. Issues 16-bit fetch requests to instruction memory and buffers in-order responses in a small FIFO. Presents one registered instruction plus its PC per cycle to decode, holds it while decode stalls, and flushes on branch redirect.

---
 rtl/fetch_block_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_block.sv | 131 +++++++++++++
 tb/tb_fetch_block.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_block_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_block_pkg;

  // Every Thumb instruction fetched here is one halfword.
  localparam int THUMB_INSTR_BYTES = 2;

  // Raw 16-bit Thumb instruction handed to decode.
  typedef logic [15:0] instruction;

  // Decode-side stall request; STALL freezes the fetch output register.
  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } stall_pipeline_sig;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} entries between the memory
// response port and the fetch output register.
module fetch_fifo
  import fetch_block_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_block.sv
// Instruction-fetch stage: issues halfword fetches under a credit limit,
// buffers in-order responses and presents one registered instruction per
// cycle to decode. Branch redirects flush the buffer and discard the
// responses still in flight.
module fetch_block
  import fetch_block_pkg::*;
#(
  parameter int               WORD       = 32,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [WORD-1:0]  RESET_PC   = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  stall_pipeline_sig stall_i,
  input  logic              branch_taken_i,
  input  logic [WORD-1:0]   branch_target_i,
  output logic              imem_req_o,
  output logic [WORD-1:0]   imem_addr_o,
  input  logic              imem_ready_i,
  input  logic              imem_rvalid_i,
  input  logic [15:0]       imem_rdata_i,
  output instruction        instruction_o,
  output logic [WORD-1:0]   program_counter_o,
  output logic              instr_valid_o
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int EW = WORD + 16;
  localparam logic [WORD-1:0] PC_STEP = WORD'(THUMB_INSTR_BYTES);

  logic [WORD-1:0] fetch_pc;
  logic [WORD-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   out_next;
  logic [CW:0]     in_use;
  logic [WORD-1:0] target_aligned;
  logic            accept;
  logic            rsp_keep;
  logic            pop;

  logic [EW-1:0]   fifo_wdata;
  logic [EW-1:0]   fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Credit: requests in flight plus buffered entries never exceed the depth,
  // so every response always has a free slot.
  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_o     = reset_i && !branch_taken_i &&
                          (in_use < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr_o    = fetch_pc;
  assign accept         = imem_req_o && imem_ready_i;
  assign target_aligned = branch_target_i & ~PC_STEP'(1);

  // A response landing in a branch cycle belongs to the old stream.
  assign rsp_keep   = imem_rvalid_i && (discard == '0) && !branch_taken_i;
  assign pop        = !branch_taken_i && (stall_i == NORMAL) && !fifo_empty;
  assign fifo_wdata = {resp_pc, imem_rdata_i};

  // In-flight count after this edge; on a branch it is exactly the number
  // of responses that must be thrown away.
  assign out_next = outstanding + CW'(accept) - CW'(imem_rvalid_i);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (rsp_keep && !fifo_full),
    .pop     (pop),
    .clear   (branch_taken_i),
    .wdata   (fifo_wdata),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Fetch/response PCs and the in-flight and discard counters.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (branch_taken_i) begin
        fetch_pc <= target_aligned;
        resp_pc  <= target_aligned;
        discard  <= out_next;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (imem_rvalid_i) begin
          if (discard == '0) begin
            resp_pc <= resp_pc + PC_STEP;
          end else begin
            discard <= discard - 1'b1;
          end
        end
      end
    end
  end

  // Output register to decode: holds under stall, bubbles when starved,
  // and drops validity on a redirect while keeping the stale data fields.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      instruction_o     <= '0;
      program_counter_o <= '0;
      instr_valid_o     <= 1'b0;
    end else if (branch_taken_i) begin
      instr_valid_o <= 1'b0;
    end else if (stall_i == NORMAL) begin
      if (!fifo_empty) begin
        instruction_o     <= fifo_rdata[15:0];
        program_counter_o <= fifo_rdata[EW-1:16];
        instr_valid_o     <= 1'b1;
      end else begin
        instr_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_block.sv
`timescale 1ns/1ps
module tb_fetch_block;
  import fetch_block_pkg::*;

  logic              clk_i = 1'b0;
  logic              reset_i;
  stall_pipeline_sig stall_i;
  logic              branch_taken_i;
  logic [31:0]       branch_target_i;
  logic              imem_req_o;
  logic [31:0]       imem_addr_o;
  logic              imem_ready_i;
  logic              imem_rvalid_i;
  logic [15:0]       imem_rdata_i;
  instruction        instruction_o;
  logic [31:0]       program_counter_o;
  logic              instr_valid_o;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t pend[$];
  int   cyc = 0;
  int   lat = 1;

  fetch_block dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .stall_i           (stall_i),
    .branch_taken_i    (branch_taken_i),
    .branch_target_i   (branch_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ready_i      (imem_ready_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .instruction_o     (instruction_o),
    .program_counter_o (program_counter_o),
    .instr_valid_o     (instr_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Credit rule: a kept response must never meet a full buffer.
  always @(negedge clk_i) begin
    if (reset_i === 1'b1) begin
      checks++;
      if (dut.rsp_keep === 1'b1 && dut.u_fifo.full === 1'b1)
        $display("FAIL push_while_full: push=1 full=1 at t=%0t, required no push when full", $time);
      else
        passed++;
    end
  end

  function automatic logic [15:0] rd_of(input logic [31:0] a);
    return 16'h1000 + a[16:1];
  endfunction

  // One clock of the memory model: records an accepted request, retires the
  // response consumed on this edge and presents the next due response.
  task automatic step();
    logic        acc;
    logic        rsp;
    logic [31:0] a;
    req_t        r;
    #1;
    acc = imem_req_o && imem_ready_i;
    a   = imem_addr_o;
    rsp = imem_rvalid_i;
    @(posedge clk_i);
    cyc++;
    if (rsp && pend.size() > 0) void'(pend.pop_front());
    if (acc) begin
      r.addr = a;
      r.due  = cyc + lat;
      pend.push_back(r);
    end
    @(negedge clk_i);
    if (pend.size() > 0 && pend[0].due == cyc + 1) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = rd_of(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic do_reset(input int l);
    lat             = l;
    reset_i         = 1'b0;
    stall_i         = NORMAL;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    imem_ready_i    = 1'b1;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = '0;
    pend.delete();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    cyc     = 0;
  endtask

  task automatic test_reset();
    lat = 1; reset_i = 1'b0; stall_i = NORMAL; branch_taken_i = 1'b0;
    branch_target_i = '0; imem_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    pend.delete();
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (instruction_o !== 16'h0) $display("FAIL reset_instr: got %h want 0000", instruction_o); else passed++;
    checks++; if (program_counter_o !== 32'h0) $display("FAIL reset_pc: got %h want 0", program_counter_o); else passed++;
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid_o); else passed++;
    checks++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req_o); else passed++;
    checks++; if (imem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr_o); else passed++;
    reset_i = 1'b1;
    cyc     = 0;
    #1;
    checks++; if (imem_req_o !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req_o); else passed++;
  endtask

  task automatic test_stream();
    int exp_req[8] = '{1, 1, 0, 1, 1, 0, 1, 1};
    int exp_v[8]   = '{0, 0, 1, 1, 0, 1, 1, 0};
    int exp_pc[8]  = '{0, 0, 0, 2, 2, 4, 6, 6};
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (imem_req_o !== exp_req[i][0]) $display("FAIL stream_req[%0d]: got %b want %0d", i, imem_req_o, exp_req[i]); else passed++;
      step();
      checks++;
      if (instr_valid_o !== exp_v[i][0]) $display("FAIL stream_valid[%0d]: got %b want %0d", i, instr_valid_o, exp_v[i]); else passed++;
      checks++;
      if (program_counter_o !== 32'(exp_pc[i])) $display("FAIL stream_pc[%0d]: got %h want %h", i, program_counter_o, exp_pc[i]); else passed++;
      if (exp_v[i] == 1) begin
        checks++;
        if (instruction_o !== rd_of(32'(exp_pc[i]))) $display("FAIL stream_instr[%0d]: got %h want %h", i, instruction_o, rd_of(32'(exp_pc[i]))); else passed++;
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    repeat (6) step();
    checks++; if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h4) $display("FAIL stall_pre: got v=%b pc=%h want v=1 pc=4", instr_valid_o, program_counter_o); else passed++;
    checks++; if (imem_req_o !== 1'b1) $display("FAIL stall_req_pre: got %b want 1", imem_req_o); else passed++;
    stall_i = STALL;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h4 || instruction_o !== 16'h1002)
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h ins=%h want v=1 pc=4 ins=1002", i, instr_valid_o, program_counter_o, instruction_o);
      else passed++;
      if (i < 2) begin
        checks++;
        if (imem_req_o !== 1'b0) $display("FAIL stall_req_drop[%0d]: got %b want 0", i, imem_req_o); else passed++;
      end
    end
    stall_i = NORMAL;
    step();
    checks++; if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h6) $display("FAIL stall_rel6: got v=%b pc=%h want v=1 pc=6", instr_valid_o, program_counter_o); else passed++;
    step();
    checks++; if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h8) $display("FAIL stall_rel8: got v=%b pc=%h want v=1 pc=8", instr_valid_o, program_counter_o); else passed++;
    step();
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL stall_bubble: got v=%b want 0", instr_valid_o); else passed++;
    step();
    checks++; if (instr_valid_o !== 1'b1 || program_counter_o !== 32'ha) $display("FAIL stall_rel10: got v=%b pc=%h want v=1 pc=a", instr_valid_o, program_counter_o); else passed++;
  endtask

  task automatic test_branch();
    do_reset(3);
    step();
    step();
    checks++; if (imem_req_o !== 1'b0) $display("FAIL br_credit: got req=%b want 0", imem_req_o); else passed++;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h101;
    step();
    branch_taken_i = 1'b0;
    checks++; if (dut.discard !== 2'd2) $display("FAIL br_discard: got %0d want 2", dut.discard); else passed++;
    checks++; if (imem_addr_o !== 32'h100) $display("FAIL br_addr: got %h want 100", imem_addr_o); else passed++;
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL br_valid: got %b want 0", instr_valid_o); else passed++;
    step();
    checks++; if (dut.discard !== 2'd1) $display("FAIL br_discard1: got %0d want 1", dut.discard); else passed++;
    step();
    checks++; if (dut.discard !== 2'd0) $display("FAIL br_discard0: got %0d want 0", dut.discard); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_valid_o !== 1'b0 || program_counter_o !== 32'h0)
        $display("FAIL br_gap[%0d]: got v=%b pc=%h want v=0 pc=0", i, instr_valid_o, program_counter_o);
      else passed++;
    end
    step();
    checks++;
    if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h100 || instruction_o !== 16'h1080)
      $display("FAIL br_target: got v=%b pc=%h ins=%h want v=1 pc=100 ins=1080", instr_valid_o, program_counter_o, instruction_o);
    else passed++;
    step();
    checks++; if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h102) $display("FAIL br_next: got v=%b pc=%h want v=1 pc=102", instr_valid_o, program_counter_o); else passed++;
  endtask

  task automatic test_branch_stall();
    do_reset(1);
    repeat (4) step();
    checks++; if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h2) $display("FAIL bs_pre: got v=%b pc=%h want v=1 pc=2", instr_valid_o, program_counter_o); else passed++;
    stall_i         = STALL;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h200;
    step();
    branch_taken_i = 1'b0;
    stall_i        = NORMAL;
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL bs_valid: got %b want 0", instr_valid_o); else passed++;
    checks++; if (program_counter_o !== 32'h2) $display("FAIL bs_pc_hold: got %h want 2", program_counter_o); else passed++;
    checks++; if (dut.u_fifo.empty !== 1'b1) $display("FAIL bs_fifo_empty: got %b want 1", dut.u_fifo.empty); else passed++;
    checks++; if (dut.discard !== 2'd0) $display("FAIL bs_discard: got %0d want 0", dut.discard); else passed++;
    checks++; if (imem_addr_o !== 32'h200) $display("FAIL bs_addr: got %h want 200", imem_addr_o); else passed++;
    step();
    step();
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL bs_gap: got %b want 0", instr_valid_o); else passed++;
    step();
    checks++;
    if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h200 || instruction_o !== 16'h1100)
      $display("FAIL bs_target: got v=%b pc=%h ins=%h want v=1 pc=200 ins=1100", instr_valid_o, program_counter_o, instruction_o);
    else passed++;
  endtask

  task automatic test_ready_toggle();
    int exp_addr[7] = '{0, 2, 2, 4, 4, 6, 6};
    int exp_v[7]    = '{0, 0, 1, 0, 1, 0, 1};
    int exp_pc[7]   = '{0, 0, 0, 0, 2, 2, 4};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      imem_ready_i = (i % 2 == 0);
      #1;
      checks++;
      if (imem_addr_o !== 32'(exp_addr[i])) $display("FAIL rdy_addr[%0d]: got %h want %h", i, imem_addr_o, exp_addr[i]); else passed++;
      step();
      checks++;
      if (instr_valid_o !== exp_v[i][0] || program_counter_o !== 32'(exp_pc[i]))
        $display("FAIL rdy_out[%0d]: got v=%b pc=%h want v=%0d pc=%h", i, instr_valid_o, program_counter_o, exp_v[i], exp_pc[i]);
      else passed++;
    end
    imem_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    repeat (3) step();
    stall_i = STALL;
    step();
    step();
    checks++; if (dut.u_fifo.full !== 1'b1) $display("FAIL rm_full: got %b want 1", dut.u_fifo.full); else passed++;
    checks++; if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h0) $display("FAIL rm_pre: got v=%b pc=%h want v=1 pc=0", instr_valid_o, program_counter_o); else passed++;
    #2;
    reset_i = 1'b0;
    #1;
    checks++;
    if (instruction_o !== 16'h0 || program_counter_o !== 32'h0 || instr_valid_o !== 1'b0)
      $display("FAIL rm_outputs: got ins=%h pc=%h v=%b want 0 0 0", instruction_o, program_counter_o, instr_valid_o);
    else passed++;
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) $display("FAIL rm_req: got req=%b addr=%h want 0 0", imem_req_o, imem_addr_o); else passed++;
    checks++; if (dut.u_fifo.empty !== 1'b1) $display("FAIL rm_empty: got %b want 1", dut.u_fifo.empty); else passed++;
    pend.delete();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    stall_i       = NORMAL;
    @(negedge clk_i);
    reset_i = 1'b1;
    cyc     = 0;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) $display("FAIL rm_restart: got req=%b addr=%h want 1 0", imem_req_o, imem_addr_o); else passed++;
    repeat (3) step();
    checks++;
    if (instr_valid_o !== 1'b1 || program_counter_o !== 32'h0 || instruction_o !== 16'h1000)
      $display("FAIL rm_first: got v=%b pc=%h ins=%h want v=1 pc=0 ins=1000", instr_valid_o, program_counter_o, instruction_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_stall();
    test_ready_toggle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1);
  end

endmodule
